router_in_chn_ctrl: RTL and testbench
=====================================

// Module: router_in_chn_ctrl
// PURPOSE
//  Parametrised router input-channel controller; next generation of the 4-port input FSM.
//  Parses header {length,addr}, steers header+payload to one of num_ports output FIFOs.
//  Adds FIFO backpressure, a stall timeout, error codes/counter and optional parity check.
//  Sits between the router ingress pins and the per-port output FIFOs.
// PARAMETERS
//  data_size        8   byte width of i_data_in / o_data2fifo_out
//  pkt_length_bits  5   header MSBs: payload length, 1..2**pkt_length_bits-1
//  pkt_addr_bits    data_size-pkt_length_bits (3)   header LSBs: destination port
//  num_ports        4   output FIFOs; 1..2**pkt_addr_bits
//  timeout_cyc      16  max consecutive idle (i_ch_en=0) cycles mid-packet
//  err_cnt_bits     8   width of saturating error counter
// PORTS
//  i_clk            in   1              clock, all logic posedge
//  i_rstn           in   1              synchronous active-low reset
//  i_ch_en          in   1              byte on i_data_in valid this cycle
//  i_data_in        in   data_size      header / payload / parity byte
//  i_clr_errors     in   1              clear o_error, o_err_code, o_err_cnt
//  i_fifo_full      in   num_ports      per-FIFO almost-full (<=1 free entry)
//  o_ready          out  1              byte consumed when i_ch_en && o_ready
//  o_busy           out  1              packet in progress (state != IDLE)
//  o_data2fifo_out  out  data_size      registered write data
//  o_pkt_to_fifo_en out  num_ports      registered one-hot FIFO write enable
//  o_pkt_addr       out  pkt_addr_bits  latched destination of current packet
//  o_pkt_done       out  1              1-cycle pulse at packet end (good or bad)
//  o_pkt_bad        out  1              qualifies o_pkt_done: packet errored
//  o_error          out  1              sticky error flag
//  o_err_code       out  3              code of first error since clear (err_code_e)
//  o_err_cnt        out  err_cnt_bits   saturating error count
// BEHAVIOUR
//  - Reset (i_rstn=0 at posedge): state IDLE; all outputs 0; counters 0. Mid-packet reset aborts silently.
//  - Write latency: consumed byte appears on o_data2fifo_out with o_pkt_to_fifo_en[addr]=1 next cycle.
//  - IDLE: o_ready = !(addr<num_ports && i_fifo_full[addr]) (combinational on i_data_in).
//    On consume: len=0 -> ERR_LEN0, no write, stay IDLE; addr>=num_ports -> ERR_ADDR, go DROP;
//    else write header, latch addr/len, go PAYLOAD.
//  - PAYLOAD: o_ready = !i_fifo_full[addr]; each consume writes byte, decrements len;
//    last byte -> PARITY (macro on) or IDLE with o_pkt_done=1, o_pkt_bad=0.
//  - DROP: o_ready=1; consumes len bytes (+parity if macro) without writing; end: o_pkt_done, o_pkt_bad.
//  - Timeout: in PAYLOAD/PARITY/DROP, cnt of consecutive cycles with i_ch_en=0; reaching timeout_cyc ->
//    ERR_TIMEOUT, IDLE, o_pkt_done+o_pkt_bad. Any consume or backpressure-held cycle resets cnt.
//  - Errors: o_error set, o_err_code captured only if o_error was 0, o_err_cnt +1 saturating at all-ones.
//    i_clr_errors with simultaneous new error: new error wins (o_error=1, code=new, cnt=1).
//  - Back-to-back packets: header accepted in IDLE the cycle after the last byte; no bubble required.
// CONFIGURATION
//  ROUTER_PARITY_CHK_EN defined: after payload, one parity byte expected = XOR of header and payload;
//   not written to FIFO; mismatch -> ERR_PARITY, o_pkt_bad=1 on o_pkt_done. DROP also consumes it.
//  Undefined: no PARITY state; packet ends at last payload byte; ERR_PARITY never raised.
// STRUCTURE
//  router_pkg: state_e {IDLE,PAYLOAD,PARITY,DROP}; err_code_e {ERR_NONE=0,ERR_LEN0,ERR_ADDR,
//   ERR_TIMEOUT,ERR_PARITY}; header field extract functions.
//  Sub-module router_err_tracker: sticky flag, first-code capture, saturating counter, clear priority.
// TESTING
//  1. hdr len=3 addr=2, 3 bytes, ch_en held -> en[2] 4 cycles, header then data, o_pkt_done, no error.
//  2. i_fifo_full[1]=1 for 5 cycles mid-packet to port 1 -> o_ready=0, no writes, no timeout, resumes.
//  3. hdr addr=5 (num_ports=4) len=2 -> ERR_ADDR, 2 bytes dropped, no en, o_pkt_bad=1, code=ERR_ADDR.
//  4. ch_en low 16 cycles mid-payload -> ERR_TIMEOUT, IDLE; next packet routed normally.
//  5. hdr len=0 then i_clr_errors same cycle as hdr addr=7 -> o_err_cnt=1, code=ERR_ADDR.
//  6. (macro on) wrong parity byte -> ERR_PARITY, o_pkt_bad=1; 255 errors -> o_err_cnt stays 255.

Source files
------------

// File: rtl/router_pkg.sv
// Shared state/error encodings and header field helpers for the router input channel.
package router_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    PARITY  = 2'd2,
    DROP    = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    ERR_NONE    = 3'd0,
    ERR_LEN0    = 3'd1,
    ERR_ADDR    = 3'd2,
    ERR_TIMEOUT = 3'd3,
    ERR_PARITY  = 3'd4
  } err_code_e;

  localparam int unsigned HDR_MAX_W = 32;

  // Header is {length, addr}; callers zero-extend the byte and truncate the result.
  function automatic logic [HDR_MAX_W-1:0] hdr_len(input logic [HDR_MAX_W-1:0] hdr,
                                                   input int unsigned addr_bits);
    return hdr >> addr_bits;
  endfunction

  function automatic logic [HDR_MAX_W-1:0] hdr_addr(input logic [HDR_MAX_W-1:0] hdr,
                                                    input int unsigned addr_bits);
    return hdr & ((HDR_MAX_W'(1) << addr_bits) - HDR_MAX_W'(1));
  endfunction

endpackage

// File: rtl/router_err_tracker.sv
// Sticky error flag, first-error code capture and saturating error counter.
module router_err_tracker
  import router_pkg::*;
#(
  parameter int unsigned cnt_bits = 8
) (
  input  logic                i_clk,
  input  logic                i_rstn,
  input  logic                i_clr,
  input  logic                i_err_vld,
  input  err_code_e           i_err_code,
  output logic                o_error,
  output err_code_e           o_err_code,
  output logic [cnt_bits-1:0] o_err_cnt
);

  logic                error_q, error_d;
  err_code_e           code_q, code_d;
  logic [cnt_bits-1:0] cnt_q, cnt_d;

  // A clear in the same cycle as a new error restarts tracking from that error.
  always_comb begin
    error_d = error_q;
    code_d  = code_q;
    cnt_d   = cnt_q;
    if (i_clr) begin
      error_d = i_err_vld;
      code_d  = i_err_vld ? i_err_code : ERR_NONE;
      cnt_d   = i_err_vld ? cnt_bits'(1) : '0;
    end else if (i_err_vld) begin
      error_d = 1'b1;
      if (!error_q) code_d = i_err_code;
      if (cnt_q != '1) cnt_d = cnt_q + cnt_bits'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      error_q <= 1'b0;
      code_q  <= ERR_NONE;
      cnt_q   <= '0;
    end else begin
      error_q <= error_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_error    = error_q;
  assign o_err_code = code_q;
  assign o_err_cnt  = cnt_q;

endmodule

// File: rtl/router_in_chn_ctrl.sv
// Router input-channel controller: parses {length,addr} headers and steers packets to a port FIFO.
// Define ROUTER_PARITY_CHK_EN to expect and check a trailing XOR parity byte per packet.
module router_in_chn_ctrl
  import router_pkg::*;
#(
  parameter int unsigned data_size       = 8,
  parameter int unsigned pkt_length_bits = 5,
  parameter int unsigned pkt_addr_bits   = data_size - pkt_length_bits,
  parameter int unsigned num_ports       = 4,
  parameter int unsigned timeout_cyc     = 16,
  parameter int unsigned err_cnt_bits    = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rstn,
  input  logic                     i_ch_en,
  input  logic [data_size-1:0]     i_data_in,
  input  logic                     i_clr_errors,
  input  logic [num_ports-1:0]     i_fifo_full,
  output logic                     o_ready,
  output logic                     o_busy,
  output logic [data_size-1:0]     o_data2fifo_out,
  output logic [num_ports-1:0]     o_pkt_to_fifo_en,
  output logic [pkt_addr_bits-1:0] o_pkt_addr,
  output logic                     o_pkt_done,
  output logic                     o_pkt_bad,
  output logic                     o_error,
  output logic [2:0]               o_err_code,
  output logic [err_cnt_bits-1:0]  o_err_cnt
);

  localparam int unsigned LEN_W  = pkt_length_bits;
  localparam int unsigned ADDR_W = pkt_addr_bits;
  localparam int unsigned TO_W   = $clog2(timeout_cyc + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(timeout_cyc - 1);
`ifdef ROUTER_PARITY_CHK_EN
  // Dropped packets also carry a parity byte, so DROP runs one byte past the length.
  localparam logic [LEN_W-1:0] DROP_LAST = '0;
`else
  localparam logic [LEN_W-1:0] DROP_LAST = LEN_W'(1);
`endif

  function automatic logic port_full(input logic [num_ports-1:0] full,
                                     input logic [ADDR_W-1:0]    a);
    logic f;
    f = 1'b0;
    for (int unsigned p = 0; p < num_ports; p++) begin
      if (a == ADDR_W'(p)) f = full[p];
    end
    return f;
  endfunction

  function automatic logic [num_ports-1:0] port_onehot(input logic [ADDR_W-1:0] a);
    logic [num_ports-1:0] oh;
    oh = '0;
    for (int unsigned p = 0; p < num_ports; p++) begin
      if (a == ADDR_W'(p)) oh[p] = 1'b1;
    end
    return oh;
  endfunction

  logic [LEN_W-1:0]  in_len;
  logic [ADDR_W-1:0] in_addr;
  logic              in_addr_ok;

  assign in_len     = LEN_W'(hdr_len(HDR_MAX_W'(i_data_in), ADDR_W));
  assign in_addr    = ADDR_W'(hdr_addr(HDR_MAX_W'(i_data_in), ADDR_W));
  assign in_addr_ok = 32'(in_addr) < 32'(num_ports);

  state_e               state_q, state_d;
  logic [LEN_W-1:0]     len_q, len_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [TO_W-1:0]      to_cnt_q, to_cnt_d;
  logic [data_size-1:0] data_q, data_d;
  logic [num_ports-1:0] fifo_en_q, fifo_en_d;
  logic                 done_q, done_d;
  logic                 bad_q, bad_d;
`ifdef ROUTER_PARITY_CHK_EN
  logic [data_size-1:0] par_q, par_d;
`endif

  logic      ready;
  logic      consume;
  logic      err_vld;
  err_code_e err_code;

  always_comb begin
    ready = 1'b1;
    case (state_q)
      IDLE:    ready = !(in_addr_ok && port_full(i_fifo_full, in_addr));
      PAYLOAD: ready = !port_full(i_fifo_full, addr_q);
      default: ready = 1'b1;
    endcase
  end

  assign consume = i_ch_en && ready;

  // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    addr_d    = addr_q;
    to_cnt_d  = to_cnt_q;
    data_d    = data_q;
    fifo_en_d = '0;
    done_d    = 1'b0;
    bad_d     = 1'b0;
    err_vld   = 1'b0;
    err_code  = ERR_NONE;
`ifdef ROUTER_PARITY_CHK_EN
    par_d     = par_q;
`endif

    case (state_q)
      IDLE: begin
        if (consume) begin
          if (in_len == '0) begin
            err_vld  = 1'b1;
            err_code = ERR_LEN0;
          end else begin
            len_d    = in_len;
            addr_d   = in_addr;
            to_cnt_d = '0;
            if (!in_addr_ok) begin
              err_vld  = 1'b1;
              err_code = ERR_ADDR;
              state_d  = DROP;
            end else begin
              data_d    = i_data_in;
              fifo_en_d = port_onehot(in_addr);
              state_d   = PAYLOAD;
`ifdef ROUTER_PARITY_CHK_EN
              par_d     = i_data_in;
`endif
            end
          end
        end
      end

      PAYLOAD: begin
        if (consume) begin
          data_d    = i_data_in;
          fifo_en_d = port_onehot(addr_q);
`ifdef ROUTER_PARITY_CHK_EN
          par_d     = par_q ^ i_data_in;
`endif
          if (len_q == LEN_W'(1)) begin
`ifdef ROUTER_PARITY_CHK_EN
            state_d = PARITY;
`else
            state_d = IDLE;
            done_d  = 1'b1;
`endif
          end else begin
            len_d = len_q - LEN_W'(1);
          end
        end
      end

`ifdef ROUTER_PARITY_CHK_EN
      PARITY: begin
        if (consume) begin
          state_d = IDLE;
          done_d  = 1'b1;
          if (i_data_in != par_q) begin
            bad_d    = 1'b1;
            err_vld  = 1'b1;
            err_code = ERR_PARITY;
          end
        end
      end
`endif

      DROP: begin
        if (consume) begin
          if (len_q == DROP_LAST) begin
            state_d = IDLE;
            done_d  = 1'b1;
            bad_d   = 1'b1;
          end else begin
            len_d = len_q - LEN_W'(1);
          end
        end
      end

      default: state_d = IDLE;
    endcase

    // Stall watchdog: only cycles with no byte offered count; a held byte restarts it.
    if (state_q != IDLE) begin
      if (i_ch_en) begin
        to_cnt_d = '0;
      end else if (to_cnt_q == TO_LAST) begin
        state_d  = IDLE;
        to_cnt_d = '0;
        done_d   = 1'b1;
        bad_d    = 1'b1;
        err_vld  = 1'b1;
        err_code = ERR_TIMEOUT;
      end else begin
        to_cnt_d = to_cnt_q + TO_W'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments; reset is synchronous, sampled on the edge.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_q   <= IDLE;
      len_q     <= '0;
      addr_q    <= '0;
      to_cnt_q  <= '0;
      data_q    <= '0;
      fifo_en_q <= '0;
      done_q    <= 1'b0;
      bad_q     <= 1'b0;
`ifdef ROUTER_PARITY_CHK_EN
      par_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      addr_q    <= addr_d;
      to_cnt_q  <= to_cnt_d;
      data_q    <= data_d;
      fifo_en_q <= fifo_en_d;
      done_q    <= done_d;
      bad_q     <= bad_d;
`ifdef ROUTER_PARITY_CHK_EN
      par_q     <= par_d;
`endif
    end
  end

  err_code_e err_code_q;

  router_err_tracker #(
    .cnt_bits(err_cnt_bits)
  ) u_err (
    .i_clk      (i_clk),
    .i_rstn     (i_rstn),
    .i_clr      (i_clr_errors),
    .i_err_vld  (err_vld),
    .i_err_code (err_code),
    .o_error    (o_error),
    .o_err_code (err_code_q),
    .o_err_cnt  (o_err_cnt)
  );

  assign o_ready          = ready;
  assign o_busy           = state_q != IDLE;
  assign o_data2fifo_out  = data_q;
  assign o_pkt_to_fifo_en = fifo_en_q;
  assign o_pkt_addr       = addr_q;
  assign o_pkt_done       = done_q;
  assign o_pkt_bad        = bad_q;
  assign o_err_code       = err_code_q;

endmodule

// File: tb/tb_router_in_chn_ctrl.sv
// Self-checking bench for router_in_chn_ctrl: directed scenarios plus random packets vs a packet-level model.
module tb_router_in_chn_ctrl;

  localparam int NUM_PORTS = 4;
  localparam int E_LEN0 = 1, E_ADDR = 2, E_TIMEOUT = 3, E_PARITY = 4;
`ifdef ROUTER_PARITY_CHK_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       i_rstn, i_ch_en, i_clr_errors;
  logic [7:0] i_data_in;
  logic [3:0] i_fifo_full;
  logic       o_ready, o_busy, o_pkt_done, o_pkt_bad, o_error;
  logic [7:0] o_data2fifo_out, o_err_cnt;
  logic [3:0] o_pkt_to_fifo_en;
  logic [2:0] o_pkt_addr, o_err_code;

  always #5 clk = ~clk;

  router_in_chn_ctrl dut (
    .i_clk            (clk),
    .i_rstn           (i_rstn),
    .i_ch_en          (i_ch_en),
    .i_data_in        (i_data_in),
    .i_clr_errors     (i_clr_errors),
    .i_fifo_full      (i_fifo_full),
    .o_ready          (o_ready),
    .o_busy           (o_busy),
    .o_data2fifo_out  (o_data2fifo_out),
    .o_pkt_to_fifo_en (o_pkt_to_fifo_en),
    .o_pkt_addr       (o_pkt_addr),
    .o_pkt_done       (o_pkt_done),
    .o_pkt_bad        (o_pkt_bad),
    .o_error          (o_error),
    .o_err_code       (o_err_code),
    .o_err_cnt        (o_err_cnt)
  );

  typedef struct {
    int         port;
    logic [7:0] data;
    int         cyc;
  } wr_t;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  wr_t        wr_q[$];
  bit         done_q[$];
  wr_t        exp_wr[$];
  bit         exp_done[$];
  logic [7:0] pkt_bytes[$];

  bit exp_err;
  int exp_code, exp_cnt;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: collect FIFO writes and packet-end pulses away from the active edge.
  int  mon_n;
  wr_t mon_w;
  always @(negedge clk) begin
    if (i_rstn) begin
      if (o_pkt_to_fifo_en != 4'b0) begin
        mon_n = 0;
        mon_w.port = -1;
        for (int p = 0; p < NUM_PORTS; p++) begin
          if (o_pkt_to_fifo_en[p]) begin
            mon_w.port = p;
            mon_n++;
          end
        end
        if (mon_n > 1) mon_w.port = -2;
        mon_w.data = o_data2fifo_out;
        mon_w.cyc  = cyc;
        wr_q.push_back(mon_w);
      end
      if (o_pkt_done) done_q.push_back(o_pkt_bad);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] rand_full();
    logic [3:0] f;
    for (int p = 0; p < 4; p++) f[p] = ($urandom_range(0, 3) == 0);
    return f;
  endfunction

  task automatic note_err(input int code);
    if (!exp_err) exp_code = code;
    exp_err = 1'b1;
    if (exp_cnt < 255) exp_cnt++;
  endtask

  task automatic model_clear();
    exp_err  = 1'b0;
    exp_code = 0;
    exp_cnt  = 0;
  endtask

  task automatic clr_errors();
    i_clr_errors = 1'b1;
    @(posedge clk); #1;
    i_clr_errors = 1'b0;
    model_clear();
    check("clr_error", o_error, 0);
    check("clr_cnt", o_err_cnt, 0);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit rnd);
    int waited = 0;
    i_ch_en     = 1'b1;
    i_data_in   = b;
    i_fifo_full = rnd ? rand_full() : 4'b0;
    forever begin
      @(negedge clk);
      if (o_ready) break;
      waited++;
      if (waited > 50) begin
        check("ready_wait", o_ready, 1);
        break;
      end
      @(posedge clk); #1;
      i_fifo_full = (rnd && waited < 6) ? rand_full() : 4'b0;
    end
    @(posedge clk); #1;
    i_ch_en   = 1'b0;
    i_data_in = 8'($urandom);
  endtask

  task automatic gap(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      i_data_in = 8'($urandom);
    end
  endtask

  // Packet-level expectation: which bytes reach which FIFO, how the packet ends, which error it raises.
  task automatic expect_pkt(input int addr, input int len, input bit corrupt);
    logic [7:0] hdr, b, par;
    pkt_bytes.delete();
    exp_wr.delete();
    exp_done.delete();
    hdr = 8'((len << 3) | addr);
    pkt_bytes.push_back(hdr);
    par = hdr;
    for (int i = 0; i < len; i++) begin
      b = 8'($urandom);
      pkt_bytes.push_back(b);
      par ^= b;
    end
    if (len == 0) begin
      note_err(E_LEN0);
      return;
    end
    if (PAR) pkt_bytes.push_back(corrupt ? ~par : par);
    if (addr >= NUM_PORTS) begin
      note_err(E_ADDR);
      exp_done.push_back(1'b1);
    end else begin
      for (int i = 0; i <= len; i++) exp_wr.push_back('{addr, pkt_bytes[i], 0});
      if (PAR && corrupt) begin
        note_err(E_PARITY);
        exp_done.push_back(1'b1);
      end else begin
        exp_done.push_back(1'b0);
      end
    end
  endtask

  task automatic compare_pkt(input string tag);
    @(negedge clk);
    @(posedge clk); #1;
    check({tag, "_busy"}, o_busy, 0);
    check({tag, "_nwr"}, wr_q.size(), exp_wr.size());
    foreach (exp_wr[i]) begin
      if (i < wr_q.size()) begin
        check({tag, "_port"}, wr_q[i].port, exp_wr[i].port);
        check({tag, "_data"}, wr_q[i].data, exp_wr[i].data);
      end
    end
    check({tag, "_ndone"}, done_q.size(), exp_done.size());
    foreach (exp_done[i]) begin
      if (i < done_q.size()) check({tag, "_bad"}, done_q[i], exp_done[i]);
    end
    check({tag, "_error"}, o_error, exp_err);
    check({tag, "_code"}, o_err_code, exp_code);
    check({tag, "_cnt"}, o_err_cnt, exp_cnt);
  endtask

  task automatic run_pkt(input string tag, input int addr, input int len,
                         input bit corrupt, input bit rnd);
    wr_q.delete();
    done_q.delete();
    expect_pkt(addr, len, corrupt);
    foreach (pkt_bytes[i]) begin
      send_byte(pkt_bytes[i], rnd);
      if (rnd) gap($urandom_range(0, 4));
    end
    i_fifo_full = 4'b0;
    compare_pkt(tag);
  endtask

  initial begin
    int ra, rl;
    bit rc, any_ready;

    i_rstn       = 1'b0;
    i_ch_en      = 1'b0;
    i_clr_errors = 1'b0;
    i_data_in    = 8'h00;
    i_fifo_full  = 4'b0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", o_busy, 0);
    check("rst_en", o_pkt_to_fifo_en, 0);
    check("rst_data", o_data2fifo_out, 0);
    check("rst_addr", o_pkt_addr, 0);
    check("rst_done", o_pkt_done, 0);
    check("rst_bad", o_pkt_bad, 0);
    check("rst_error", o_error, 0);
    check("rst_code", o_err_code, 0);
    check("rst_cnt", o_err_cnt, 0);
    i_rstn = 1'b1;
    @(posedge clk); #1;

    // 1: clean packet to port 2, back-to-back bytes.
    run_pkt("t1", 2, 3, 1'b0, 1'b0);
    if (wr_q.size() == 4) check("t1_consec", wr_q[3].cyc - wr_q[0].cyc, 3);
    check("t1_addr", o_pkt_addr, 2);

    // Mid-packet reset aborts silently.
    send_byte(8'h1B, 1'b0);
    send_byte(8'h77, 1'b0);
    i_rstn = 1'b0;
    @(posedge clk); #1;
    check("mrst_busy", o_busy, 0);
    check("mrst_en", o_pkt_to_fifo_en, 0);
    check("mrst_done", o_pkt_done, 0);
    i_rstn = 1'b1;
    model_clear();
    @(posedge clk); #1;
    run_pkt("mrst_next", 3, 3, 1'b0, 1'b0);

    // 2: backpressure on port 1 between idle gaps; held cycles restart the stall count.
    wr_q.delete();
    done_q.delete();
    expect_pkt(1, 4, 1'b0);
    for (int i = 0; i < 3; i++) send_byte(pkt_bytes[i], 1'b0);
    gap(10);
    i_fifo_full = 4'b0010;
    i_ch_en     = 1'b1;
    i_data_in   = pkt_bytes[3];
    any_ready   = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (o_ready) any_ready = 1'b1;
    end
    check("t2_ready_held", any_ready, 0);
    check("t2_nwr_held", wr_q.size(), 3);
    check("t2_busy_held", o_busy, 1);
    @(posedge clk); #1;
    send_byte(pkt_bytes[3], 1'b0);
    gap(10);
    for (int i = 4; i < pkt_bytes.size(); i++) send_byte(pkt_bytes[i], 1'b0);
    compare_pkt("t2");

    // 3: bad destination is dropped.
    run_pkt("t3", 5, 2, 1'b0, 1'b0);

    // 4: stall timeout mid-payload, then a normal packet.
    clr_errors();
    wr_q.delete();
    done_q.delete();
    exp_wr.delete();
    exp_done.delete();
    send_byte(8'h20, 1'b0);
    send_byte(8'h5A, 1'b0);
    repeat (15) begin
      @(posedge clk); #1;
    end
    check("t4_busy_before", o_busy, 1);
    @(posedge clk); #1;
    check("t4_busy_after", o_busy, 0);
    check("t4_done", o_pkt_done, 1);
    check("t4_bad", o_pkt_bad, 1);
    exp_wr.push_back('{0, 8'h20, 0});
    exp_wr.push_back('{0, 8'h5A, 0});
    exp_done.push_back(1'b1);
    note_err(E_TIMEOUT);
    compare_pkt("t4");
    run_pkt("t4_next", 1, 2, 1'b0, 1'b0);

    // 5: length-0 header, then clear coinciding with a bad-address header.
    clr_errors();
    run_pkt("t5_len0", 0, 0, 1'b0, 1'b0);
    wr_q.delete();
    done_q.delete();
    expect_pkt(7, 1, 1'b0);
    model_clear();
    note_err(E_ADDR);
    i_clr_errors = 1'b1;
    send_byte(pkt_bytes[0], 1'b0);
    i_clr_errors = 1'b0;
    for (int i = 1; i < pkt_bytes.size(); i++) send_byte(pkt_bytes[i], 1'b0);
    compare_pkt("t5_clr");

`ifdef ROUTER_PARITY_CHK_EN
    // 6a: wrong parity byte.
    clr_errors();
    run_pkt("t6_par", 3, 2, 1'b1, 1'b0);
`endif

    // 6b: error counter saturates.
    clr_errors();
    wr_q.delete();
    done_q.delete();
    exp_wr.delete();
    exp_done.delete();
    repeat (260) begin
      send_byte(8'h00, 1'b0);
      note_err(E_LEN0);
    end
    compare_pkt("t6_sat");

    // Random packets with gaps and backpressure against the packet model.
    clr_errors();
    for (int k = 0; k < 60; k++) begin
      ra = $urandom_range(0, 7);
      rl = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 8);
      rc = PAR && ($urandom_range(0, 3) == 0);
      run_pkt("rnd", ra, rl, rc, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
